// File: rtl/serv_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : serv_mdu_seq
// Purpose  : Sequential RV32M multiply/divide unit, responder side of the
//            SERV extension interface. One result bit is produced per cycle:
//            shift-add for multiplies and restoring division for divides.
//            Operands are reduced to magnitudes at acceptance, and the sign is
//            re-applied in a single FIX cycle before the result is returned.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   single clock, rising edge
//   i_rst_n       in   1   asynchronous active-low reset
//   i_mdu_valid   in   1   request; sampled only in IDLE
//   i_ext_rs1     in  32   operand A (multiplicand / dividend)
//   i_ext_rs2     in  32   operand B (multiplier / divisor)
//   i_ext_funct3  in   3   MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   o_ext_rd      out 32   registered result, held until the next FIX
//   o_ext_ready   out  1   one-cycle completion pulse
// ----------------------------------------------------------------------------
// Configuration macro
//   SERV_MDU_EARLY_EN : when defined, B=0 (any op) or A=0 (multiply ops)
//                       skips CALC and completes in two cycles.
// ============================================================================
module serv_mdu_seq (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_mdu_valid,
  input  logic [31:0] i_ext_rs1,
  input  logic [31:0] i_ext_rs2,
  input  logic [2:0]  i_ext_funct3,
  output logic [31:0] o_ext_rd,
  output logic        o_ext_ready
);

  localparam logic [31:0] c_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [4:0]  c_CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched operation context
  logic [2:0]  r_funct3;
  logic [31:0] r_op;       // |A| for multiply (addend), |B| for divide (divisor)
  logic [31:0] r_hi;       // product high word / partial remainder
  logic [31:0] r_lo;       // multiplier shift reg / dividend-quotient shift reg
  logic [4:0]  r_cnt;
  logic        r_res_neg;  // product / quotient must be negated
  logic        r_rem_neg;  // remainder must be negated
  logic        r_ovr_en;   // special case result replaces the computed one
  logic [31:0] r_ovr_val;

  // --------------------------------------------------------------------------
  // Acceptance decode (operates on the live inputs, used only in IDLE)
  // --------------------------------------------------------------------------
  logic        w_is_div;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_ovf;
  logic        w_ovr_en;
  logic [31:0] w_ovr_val;
  logic        w_early;

  assign w_is_div = i_ext_funct3[2];

  // Divides: funct3[0]=0 is signed. Multiplies: MULH signs both, MULHSU only A.
  // MUL is treated as unsigned since its low word does not depend on signedness.
  assign w_a_signed = w_is_div ? ~i_ext_funct3[0]
                               : (i_ext_funct3[1:0] == 2'b01) || (i_ext_funct3[1:0] == 2'b10);
  assign w_b_signed = w_is_div ? ~i_ext_funct3[0]
                               : (i_ext_funct3[1:0] == 2'b01);

  assign w_neg_a  = w_a_signed & i_ext_rs1[31];
  assign w_neg_b  = w_b_signed & i_ext_rs2[31];
  assign w_abs_a  = w_neg_a ? (~i_ext_rs1 + 32'd1) : i_ext_rs1;
  assign w_abs_b  = w_neg_b ? (~i_ext_rs2 + 32'd1) : i_ext_rs2;
  assign w_a_zero = (i_ext_rs1 == 32'd0);
  assign w_b_zero = (i_ext_rs2 == 32'd0);
  assign w_ovf    = w_is_div & ~i_ext_funct3[0] &
                    (i_ext_rs1 == c_INT_MIN) & (i_ext_rs2 == c_ALL_ONES);

  // Special results decided up front. A zero multiply operand is included so
  // the early-exit path never has to rely on a partially computed product.
  always_comb begin
    w_ovr_en  = 1'b0;
    w_ovr_val = 32'd0;
    if (w_is_div) begin
      if (w_b_zero) begin
        w_ovr_en  = 1'b1;
        w_ovr_val = i_ext_funct3[1] ? i_ext_rs1 : c_ALL_ONES;
      end else if (w_ovf) begin
        w_ovr_en  = 1'b1;
        w_ovr_val = i_ext_funct3[1] ? 32'd0 : c_INT_MIN;
      end
    end else if (w_a_zero || w_b_zero) begin
      w_ovr_en  = 1'b1;
      w_ovr_val = 32'd0;
    end
  end

`ifdef SERV_MDU_EARLY_EN
  assign w_early = w_b_zero | (~w_is_div & w_a_zero);
`else
  assign w_early = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic        w_calc_div;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_trial;
  logic [31:0] w_hi_next;
  logic [31:0] w_lo_next;

  assign w_calc_div = r_funct3[2];

  // Shift-add: conditionally add the multiplicand to the high word, then shift
  // the 65-bit {carry, hi, lo} right; lo drains multiplier bits as product
  // bits fill in from the top.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : 33'd0);

  // Restoring step: bring the next dividend bit into the remainder and try a
  // subtract. Because the remainder stays below the divisor, bit 32 of the
  // trial result is set exactly when the subtraction borrows.
  assign w_div_shift = {r_hi, r_lo[31]};
  assign w_div_trial = w_div_shift - {1'b0, r_op};

  always_comb begin
    if (w_calc_div) begin
      if (!w_div_trial[32]) begin
        w_hi_next = w_div_trial[31:0];
        w_lo_next = {r_lo[30:0], 1'b1};
      end else begin
        w_hi_next = w_div_shift[31:0];
        w_lo_next = {r_lo[30:0], 1'b0};
      end
    end else begin
      w_hi_next = w_mul_sum[32:1];
      w_lo_next = {w_mul_sum[0], r_lo[31:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Result fix-up
  // --------------------------------------------------------------------------
  logic [63:0] w_prod_neg;
  logic [31:0] w_fix_res;

  assign w_prod_neg = ~{r_hi, r_lo} + 64'd1;

  always_comb begin
    w_fix_res = 32'd0;
    case (r_funct3)
      3'b000:                 w_fix_res = r_res_neg ? w_prod_neg[31:0]  : r_lo;
      3'b001, 3'b010, 3'b011: w_fix_res = r_res_neg ? w_prod_neg[63:32] : r_hi;
      3'b100, 3'b101:         w_fix_res = r_res_neg ? (~r_lo + 32'd1)   : r_lo;
      default:                w_fix_res = r_rem_neg ? (~r_hi + 32'd1)   : r_hi;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_mdu_valid) begin
          w_state_next = w_early ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == c_CNT_LAST) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_ext_ready = (r_state == S_DONE);

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_funct3  <= 3'd0;
      r_op      <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_cnt     <= 5'd0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_ovr_en  <= 1'b0;
      r_ovr_val <= 32'd0;
      o_ext_rd  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mdu_valid) begin
            r_funct3  <= i_ext_funct3;
            r_hi      <= 32'd0;
            r_cnt     <= 5'd0;
            r_res_neg <= w_neg_a ^ w_neg_b;
            r_rem_neg <= w_neg_a;
            r_ovr_en  <= w_ovr_en;
            r_ovr_val <= w_ovr_val;
            if (w_is_div) begin
              r_op <= w_abs_b;
              r_lo <= w_abs_a;
            end else begin
              r_op <= w_abs_a;
              r_lo <= w_abs_b;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + 5'd1;  // wraps 31 -> 0 on the way to FIX
        end
        S_FIX: begin
          o_ext_rd <= r_ovr_en ? r_ovr_val : w_fix_res;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serv_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serv_mdu_seq
// Purpose  : Self-checking bench for serv_mdu_seq. Directed RV32M vectors,
//            randomized operations against an arithmetic reference model,
//            back-to-back requests and reset in the middle of a divide.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serv_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  f3;
  logic [31:0] rd;
  logic        ready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serv_mdu_seq dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_mdu_valid  (valid),
    .i_ext_rs1    (rs1),
    .i_ext_rs2    (rs2),
    .i_ext_funct3 (f3),
    .o_ext_rd     (rd),
    .o_ext_ready  (ready)
  );

  // Reference: RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef SERV_MDU_EARLY_EN
    if (b == 32'd0 || (!op[2] && a == 32'd0)) return 2;
`endif
    return 34;
  endfunction

  // One complete transaction; cycle 0 is the IDLE cycle with valid high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string name);
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    int          exp_lat;
    int          lat;
    logic        got;
    exp_rd  = ref_model(op, a, b);
    exp_lat = ref_latency(op, a, b);
    got     = 1'b0;
    lat     = 0;
    got_rd  = 32'd0;
    @(negedge clk);
    valid = 1'b1; f3 = op; rs1 = a; rs2 = b;
    for (int n = 1; n <= 100 && !got; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        // Operands must only matter on the accept edge.
        rs1 = $urandom; rs2 = $urandom; f3 = 3'($urandom_range(0, 7));
      end
      if (ready) begin
        got = 1'b1; lat = n; got_rd = rd;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s timeout: no ready within 100 cycles, expected %0d", name, exp_lat);
      valid = 1'b0;
      return;
    end
    if (got_rd !== exp_rd) begin
      tests_failed++;
      $display("FAIL %s rd: got %h expected %h (op %0d a %h b %h)", name, got_rd, exp_rd, op, a, b);
    end
    tests_run++;
    if (lat != exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    tests_run++;
    if (ready !== 1'b0 || rd !== exp_rd) begin
      tests_failed++;
      $display("FAIL %s after-done: ready %b rd %h expected ready 0 rd %h", name, ready, rd, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; rs1 = 32'd0; rs2 = 32'd0; f3 = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0 || rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset: ready %b rd %h expected ready 0 rd 00000000", ready, rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, "mul_7_m3");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         "mulhsu_m1_2");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         "rem_m7_2");
    run_op(3'd5, 32'd100,        32'd7,         "divu_100_7");
    run_op(3'd7, 32'd100,        32'd7,         "remu_100_7");
    run_op(3'd4, 32'd5,          32'd0,         "div_by_zero");
    run_op(3'd6, 32'd5,          32'd0,         "rem_by_zero");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd0,         "rem_neg_by_zero");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, "div_overflow");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, "rem_overflow");
    run_op(3'd0, 32'd0,          32'd12345,     "mul_a_zero");
  endtask

  task automatic test_random();
    logic [31:0] v[2];
    logic [2:0]  op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0:       v[k] = 32'd0;
          1:       v[k] = 32'hFFFF_FFFF;
          2:       v[k] = 32'h8000_0000;
          3:       v[k] = 32'd1;
          default: v[k] = $urandom;
        endcase
      end
      run_op(op, v[0], v[1], "random");
    end
  endtask

  task automatic test_back_to_back();
    logic got;
    int   gap;
    int   extra;
    got = 1'b0;
    @(negedge clk);
    valid = 1'b1; f3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    for (int n = 1; n <= 100 && !got; n++) begin
      @(posedge clk); #1;
      if (ready) got = 1'b1;
    end
    tests_run++;
    if (!got || rd !== 32'd14) begin
      tests_failed++;
      $display("FAIL b2b_first: ready %b rd %h expected ready 1 rd 0000000e", got, rd);
    end
    // Keep valid high through DONE with the next request's operands.
    f3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    got = 1'b0; gap = 0;
    for (int n = 1; n <= 100 && !got; n++) begin
      @(posedge clk); #1;
      if (ready) begin got = 1'b1; gap = n; end
    end
    tests_run++;
    if (gap != 35) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %0d cycles expected 35", gap);
    end
    tests_run++;
    if (rd !== 32'd12) begin
      tests_failed++;
      $display("FAIL b2b_second_rd: got %h expected 0000000c", rd);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      if (ready) extra++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL b2b_extra_pulses: got %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    valid = 1'b1; f3 = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b0 || rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: ready %b rd %h expected ready 0 rd 00000000", ready, rd);
    end
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", pulses);
    end
    run_op(3'd0, 32'd2, 32'd3, "mul_after_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
